// File: rtl/clk_div_pkg.sv
// Shared constants for the clk_div controller, counter and their benches.
// State encoding and default ratio live here.
package clk_div_pkg;

  localparam int          WIDTH_DEF        = 16;
  localparam logic [15:0] DEFAULT_HALF_DEF = 16'd500;

  localparam logic [1:0] STOP = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

endpackage

// File: rtl/clk_div_ctrl.sv
// Sequencer for the shared counter + clock divider; glitch-free clk_out.
// Optional tick counter output under CLK_DIV_CTRL_TICK_CNT_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int              WIDTH        = WIDTH_DEF,
  parameter logic [WIDTH-1:0] DEFAULT_HALF = WIDTH'(DEFAULT_HALF_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  output logic             cnt_clr,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  ,
  output logic [15:0]      tick_cnt
`endif
);

  logic [1:0]       state_q, state_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;

  logic boundary;
  logic hs;
  logic hs_ok;
  logic hs_bad;
  logic zero_half;

  // >= rather than == so a shrunk ratio can never overrun
  assign boundary  = (cnt >= active_q - WIDTH'(1));
  assign busy      = (state_q != STOP);
  assign cfg_ready = (state_q == STOP) | (state_q == RUN);
  assign cnt_clr   = rst | (state_q == STOP)
                   | (boundary & (state_q != STOP));

  assign zero_half = (cfg_half == '0);
  assign hs        = cfg_valid & cfg_ready;
  assign hs_ok     = hs & ~zero_half;
  assign hs_bad    = hs & zero_half;

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;

  always_comb begin
    state_d   = state_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = hs_bad;
    active_d  = active_q;
    shadow_d  = shadow_q;
    unique case (state_q)
      STOP: begin
        clk_out_d = 1'b0;
        if (hs_ok) begin
          active_d = cfg_half;
          done_d   = 1'b1;
        end
        if (en) state_d = RUN;
      end
      RUN, PEND: begin
        if (boundary && !en) begin
          // park low; any staged ratio lands before stopping
          clk_out_d = 1'b0;
          state_d   = STOP;
          if (state_q == PEND) begin
            active_d = shadow_q;
            done_d   = 1'b1;
          end else if (hs_ok) begin
            active_d = cfg_half;
            done_d   = 1'b1;
          end
        end else if (boundary) begin
          clk_out_d = ~clk_out_q;
          tick_d    = ~clk_out_q;
          state_d   = RUN;
          if (state_q == PEND) begin
            active_d = shadow_q;
            done_d   = 1'b1;
          end
          if (hs_ok) begin
            shadow_d = cfg_half;
            state_d  = PEND;
          end
        end else if (hs_ok) begin
          shadow_d = cfg_half;
          state_d  = PEND;
        end
      end
      default: begin
        state_d   = STOP;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STOP;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= DEFAULT_HALF;
      shadow_q  <= DEFAULT_HALF;
    end else begin
      state_q   <= state_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      err_q     <= err_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
    end
  end

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [15:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (done_d)
      tick_cnt_d = '0;
    else if (tick_d && tick_cnt_q != 16'hFFFF)
      tick_cnt_d = tick_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl with an external counter model.
// Directed scenarios followed by randomized traffic against a reference model.
module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] cnt;
  logic        cnt_clr;
  logic        cfg_valid;
  logic [15:0] cfg_half;
  logic        cfg_ready;
  logic        cfg_done;
  logic        cfg_err;
  logic        clk_out;
  logic        tick;
  logic        busy;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif

  clk_div_ctrl #(
    .WIDTH       (16),
    .DEFAULT_HALF(16'd4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cnt      (cnt),
    .cnt_clr  (cnt_clr),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    ,
    .tick_cnt (tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  // shared free-running counter with synchronous clear
  always_ff @(posedge clk) begin
    if (cnt_clr) cnt <= '0;
    else         cnt <= cnt + 16'd1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: phase start stamp instead of a counter
  int cyc = 0;
  bit m_run, m_pend, m_clk, m_tick, m_done, m_err;
  int m_active, m_shadow, m_start;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%b exp=%b cyc=%0d",
                tag, obs, exp, cyc);
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0d exp=%0d cyc=%0d",
                tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    m_run    = 0;
    m_pend   = 0;
    m_clk    = 0;
    m_tick   = 0;
    m_done   = 0;
    m_err    = 0;
    m_active = 4;
    m_shadow = 4;
    m_start  = cyc + 1;
  endtask

  task automatic cycle();
    bit rdy, bnd, ok, bad, stp;
    bit n_run, n_pend, n_clk, n_tick, n_done, n_err;
    int n_active, n_shadow, n_start, h;
    @(negedge clk);
    h   = int'(cfg_half);
    rdy = !m_run || !m_pend;
    bnd = m_run && ((cyc - m_start) >= (m_active - 1));
    chk("clk_out", clk_out, m_clk);
    chk("tick", tick, m_tick);
    chk("cfg_done", cfg_done, m_done);
    chk("cfg_err", cfg_err, m_err);
    chk("busy", busy, m_run);
    chk("cfg_ready", cfg_ready, rdy);
    chk("cnt_clr", cnt_clr, rst || !m_run || bnd);
    ok  = cfg_valid && rdy && h != 0;
    bad = cfg_valid && rdy && h == 0;
    n_run = m_run; n_pend = m_pend; n_clk = m_clk;
    n_tick = 0; n_done = 0; n_err = bad;
    n_active = m_active; n_shadow = m_shadow;
    n_start = m_start;
    if (!m_run) begin
      n_clk   = 0;
      n_start = cyc + 1;
      if (ok) begin n_active = h; n_done = 1; end
      if (en) n_run = 1;
    end else if (bnd) begin
      n_start = cyc + 1;
      stp = !en;
      if (stp) begin
        n_clk = 0; n_run = 0; n_pend = 0;
        if (m_pend) begin n_active = m_shadow; n_done = 1; end
        else if (ok) begin n_active = h; n_done = 1; end
      end else begin
        n_clk  = !m_clk;
        n_tick = !m_clk;
        n_pend = 0;
        if (m_pend) begin n_active = m_shadow; n_done = 1; end
        if (ok) begin n_shadow = h; n_pend = 1; end
      end
    end else if (ok) begin
      n_shadow = h;
      n_pend   = 1;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_run = n_run; m_pend = n_pend; m_clk = n_clk;
      m_tick = n_tick; m_done = n_done; m_err = n_err;
      m_active = n_active; m_shadow = n_shadow;
      m_start = n_start;
    end
    cyc++;
  endtask

  // cycles until clk_out differs from its present value
  task automatic phase_len(output int n);
    logic c0;
    c0 = clk_out;
    n  = 0;
    do begin
      cycle();
      n++;
    end while (clk_out === c0 && n < 40);
  endtask

  task automatic offer(input int h);
    cfg_valid = 1'b1;
    cfg_half  = 16'(h);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (cfg_done !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, cfg_done, 1'b1);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;

    // start: first rise after 4 cycles, then period 8
    en = 1'b1;
    cycle();
    n = 0;
    do begin cycle(); n++; end
    while (clk_out !== 1'b1 && n < 20);
    chk_int("first_rise", n, 4);
    n = 0;
    do begin cycle(); n++; end
    while (tick !== 1'b1 && n < 40);
    chk_int("period", n, 8);

    // shrink to 2 mid half-period
    cycle();
    offer(2);
    chk("ready_drop", cfg_ready, 1'b0);
    wait_done("done_shrink");
    phase_len(n);
    chk_int("half_after_shrink", n, 2);
    phase_len(n);
    chk_int("half_after_shrink2", n, 2);

    // offer exactly on a boundary cycle
    n = 0;
    while (cnt_clr !== 1'b1 && n < 10) begin cycle(); n++; end
    offer(5);
    phase_len(n);
    chk_int("boundary_old_ratio", n, 2);
    chk("boundary_done", cfg_done, 1'b1);
    phase_len(n);
    chk_int("boundary_new_ratio", n, 5);

    // zero ratio is rejected
    offer(0);
    chk("err_pulse", cfg_err, 1'b1);
    chk("err_busy", busy, 1'b1);
    chk("err_ready", cfg_ready, 1'b1);
    cycle();
    chk("err_one_cycle", cfg_err, 1'b0);

    // stop while high with half=3
    offer(3);
    wait_done("done_three");
    n = 0;
    while (!(clk_out === 1'b1 && tick === 1'b1) && n < 20) begin
      cycle();
      n++;
    end
    en = 1'b0;
    phase_len(n);
    chk_int("stop_fall", n, 3);
    chk("stop_busy", busy, 1'b0);
    chk("stop_clr", cnt_clr, 1'b1);
    repeat (4) cycle();
    chk("stop_parked", clk_out, 1'b0);

    // reset during PEND discards the pending ratio
    en = 1'b1;
    repeat (2) cycle();
    offer(7);
    chk("pend_ready", cfg_ready, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_clk", clk_out, 1'b0);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    chk_int("rst_tick_cnt", int'(tick_cnt), 0);
`endif
    cycle();
    n = 0;
    do begin cycle(); n++; end
    while (clk_out !== 1'b1 && n < 20);
    chk_int("rise_after_rst", n, 4);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      en        = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_half  = 16'($urandom_range(0, 6));
      cycle();
    end
    rst       = 1'b0;
    cfg_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
